// File: rtl/axis_frame_receiver.sv
// AXI-stream video receiver: 2-entry skid buffer, SOF/EOL framing tracker and registered pixel output.
// Optional saturating error counter (err_cnt / err_cnt_clr) is built when AXIS_ERR_CNT_EN is defined.
module axis_frame_receiver #(
  parameter int AXIS_DATA_WIDTH = 24,
  parameter int IMG_WIDTH       = 960,
  parameter int IMG_HEIGHT      = 540,
  parameter int COL_W           = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1,
  parameter int ROW_W           = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1
) (
  input  logic                         aclk,
  input  logic                         arst,
  input  logic                         s_axis_tvalid,
  output logic                         s_axis_tready,
  input  logic                         s_axis_tid,
  input  logic [AXIS_DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic [AXIS_DATA_WIDTH/8-1:0] s_axis_tstrb,
  input  logic [AXIS_DATA_WIDTH/8-1:0] s_axis_tkeep,
  input  logic                         s_axis_tlast,
  input  logic                         s_axis_tdest,
  input  logic                         s_axis_user,
  output logic                         pix_valid,
  input  logic                         pix_ready,
  output logic [AXIS_DATA_WIDTH-1:0]   pix_data,
  output logic [COL_W-1:0]             pix_col,
  output logic [ROW_W-1:0]             pix_row,
  output logic                         pix_sof,
  output logic                         pix_eol,
  output logic                         pix_eof,
  output logic                         err_sof,
  output logic                         err_early_last,
  output logic                         err_late_last,
  output logic                         frame_done
`ifdef AXIS_ERR_CNT_EN
  ,
  input  logic                         err_cnt_clr,
  output logic [15:0]                  err_cnt
`endif
);

  localparam logic [0:0] S_WAIT_SOF = 1'b0;
  localparam logic [0:0] S_ACTIVE   = 1'b1;

  localparam logic [COL_W-1:0] LAST_COL = COL_W'(IMG_WIDTH - 1);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(IMG_HEIGHT - 1);

  // Skid buffer storage and control
  logic [AXIS_DATA_WIDTH-1:0] r_fifo_data [2];
  logic [1:0]                 r_fifo_user;
  logic [1:0]                 r_fifo_last;
  logic                       r_wr_ptr;
  logic                       r_rd_ptr;
  logic [1:0]                 r_count;
  logic                       r_tready;

  // Framing state
  logic [0:0]       r_state;
  logic [COL_W-1:0] r_col;
  logic [ROW_W-1:0] r_row;
  logic             r_drop_run;

  // Output register
  logic                       r_pix_valid;
  logic [AXIS_DATA_WIDTH-1:0] r_pix_data;
  logic [COL_W-1:0]           r_pix_col;
  logic [ROW_W-1:0]           r_pix_row;
  logic                       r_pix_sof;
  logic                       r_pix_eol;
  logic                       r_pix_eof;
  logic                       r_err_sof;
  logic                       r_err_early;
  logic                       r_err_late;

  logic                       w_fifo_empty;
  logic                       w_in_fire;
  logic                       w_in_beat;
  logic                       w_src_valid;
  logic [AXIS_DATA_WIDTH-1:0] w_src_data;
  logic                       w_src_user;
  logic                       w_src_last;
  logic                       w_drop;
  logic                       w_out_can;
  logic                       w_consume;
  logic                       w_load;
  logic                       w_push;
  logic                       w_pop;
  logic [1:0]                 w_count_nxt;
  logic [COL_W-1:0]           w_cur_col;
  logic [ROW_W-1:0]           w_cur_row;
  logic                       w_last_col;
  logic                       w_line_end;
  logic                       w_eof;
  logic                       w_err_sof;
  logic                       w_unused_inputs;

  assign w_unused_inputs = ^{s_axis_tid, s_axis_tdest, s_axis_tstrb};

  assign w_fifo_empty = (r_count == 2'd0);
  assign w_in_fire    = s_axis_tvalid && r_tready;
  assign w_in_beat    = w_in_fire && (s_axis_tkeep != '0);

  // When the skid buffer is empty the incoming beat bypasses it for single-cycle latency.
  always_comb begin
    w_src_valid = 1'b0;
    w_src_data  = '0;
    w_src_user  = 1'b0;
    w_src_last  = 1'b0;
    if (w_fifo_empty) begin
      w_src_valid = w_in_beat;
      w_src_data  = s_axis_tdata;
      w_src_user  = s_axis_user;
      w_src_last  = s_axis_tlast;
    end else begin
      w_src_valid = 1'b1;
      w_src_data  = r_fifo_data[r_rd_ptr];
      w_src_user  = r_fifo_user[r_rd_ptr];
      w_src_last  = r_fifo_last[r_rd_ptr];
    end
  end

  assign w_drop    = (r_state == S_WAIT_SOF) && !w_src_user;
  assign w_out_can = !r_pix_valid || pix_ready;
  assign w_consume = w_src_valid && (w_drop || w_out_can);
  assign w_load    = w_consume && !w_drop;
  assign w_push    = w_in_beat && !(w_fifo_empty && w_consume);
  assign w_pop     = !w_fifo_empty && w_consume;

  always_comb begin
    w_count_nxt = r_count;
    if (w_push && !w_pop) begin
      w_count_nxt = r_count + 2'd1;
    end else if (!w_push && w_pop) begin
      w_count_nxt = r_count - 2'd1;
    end
  end

  // A start-of-frame beat always restarts the position at (0,0), even mid-frame.
  assign w_cur_col  = w_src_user ? '0 : r_col;
  assign w_cur_row  = w_src_user ? '0 : r_row;
  assign w_last_col = (w_cur_col == LAST_COL);
  assign w_line_end = w_src_last || w_last_col;
  assign w_eof      = w_line_end && (w_cur_row == LAST_ROW);
  assign w_err_sof  = (w_consume && w_drop && !r_drop_run) ||
                      (w_load && (r_state == S_ACTIVE) && w_src_user);

  always_ff @(posedge aclk) begin
    if (w_push) begin
      r_fifo_data[r_wr_ptr] <= s_axis_tdata;
    end
  end

  always_ff @(posedge aclk or posedge arst) begin
    if (arst) begin
      r_fifo_user <= '0;
      r_fifo_last <= '0;
      r_wr_ptr    <= 1'b0;
      r_rd_ptr    <= 1'b0;
      r_count     <= '0;
      r_tready    <= 1'b0;
    end else begin
      r_count  <= w_count_nxt;
      r_tready <= (w_count_nxt != 2'd2);
      if (w_push) begin
        r_fifo_user[r_wr_ptr] <= s_axis_user;
        r_fifo_last[r_wr_ptr] <= s_axis_tlast;
        r_wr_ptr              <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
    end
  end

  always_ff @(posedge aclk or posedge arst) begin
    if (arst) begin
      r_state    <= S_WAIT_SOF;
      r_col      <= '0;
      r_row      <= '0;
      r_drop_run <= 1'b0;
    end else if (w_consume) begin
      if (w_drop) begin
        r_drop_run <= 1'b1;
      end else begin
        r_drop_run <= 1'b0;
        if (w_eof) begin
          r_state <= S_WAIT_SOF;
          r_col   <= '0;
          r_row   <= '0;
        end else if (w_line_end) begin
          r_state <= S_ACTIVE;
          r_col   <= '0;
          r_row   <= w_cur_row + ROW_W'(1);
        end else begin
          r_state <= S_ACTIVE;
          r_col   <= w_cur_col + COL_W'(1);
          r_row   <= w_cur_row;
        end
      end
    end
  end

  always_ff @(posedge aclk or posedge arst) begin
    if (arst) begin
      r_pix_valid <= 1'b0;
      r_pix_data  <= '0;
      r_pix_col   <= '0;
      r_pix_row   <= '0;
      r_pix_sof   <= 1'b0;
      r_pix_eol   <= 1'b0;
      r_pix_eof   <= 1'b0;
      r_err_sof   <= 1'b0;
      r_err_early <= 1'b0;
      r_err_late  <= 1'b0;
    end else begin
      r_err_sof   <= w_err_sof;
      r_err_early <= w_load && w_src_last && !w_last_col;
      r_err_late  <= w_load && w_last_col && !w_src_last;
      if (w_load) begin
        r_pix_valid <= 1'b1;
        r_pix_data  <= w_src_data;
        r_pix_col   <= w_cur_col;
        r_pix_row   <= w_cur_row;
        r_pix_sof   <= w_src_user;
        r_pix_eol   <= w_line_end;
        r_pix_eof   <= w_eof;
      end else if (pix_ready) begin
        r_pix_valid <= 1'b0;
      end
    end
  end

`ifdef AXIS_ERR_CNT_EN
  logic [15:0] r_err_cnt;
  logic [1:0]  w_err_inc;
  logic [16:0] w_err_sum;

  assign w_err_inc = 2'(r_err_sof) + 2'(r_err_early) + 2'(r_err_late);
  assign w_err_sum = {1'b0, r_err_cnt} + 17'(w_err_inc);

  always_ff @(posedge aclk or posedge arst) begin
    if (arst) begin
      r_err_cnt <= '0;
    end else if (err_cnt_clr) begin
      r_err_cnt <= '0;
    end else if (w_err_sum[16]) begin
      r_err_cnt <= '1;
    end else begin
      r_err_cnt <= w_err_sum[15:0];
    end
  end

  assign err_cnt = r_err_cnt;
`endif

  assign s_axis_tready  = r_tready;
  assign pix_valid      = r_pix_valid;
  assign pix_data       = r_pix_data;
  assign pix_col        = r_pix_col;
  assign pix_row        = r_pix_row;
  assign pix_sof        = r_pix_sof;
  assign pix_eol        = r_pix_eol;
  assign pix_eof        = r_pix_eof;
  assign err_sof        = r_err_sof;
  assign err_early_last = r_err_early;
  assign err_late_last  = r_err_late;
  assign frame_done     = r_pix_valid && pix_ready && r_pix_eof;

endmodule
